// File: rtl/ctr_block_unpacker_pkg.sv
// ctr_pkg: shared constants and types for the CTR block unpacker.
//   CTR_DATA_WIDTH : block width coming from the CTR core
//   CTR_PIX_WIDTH  : width of one output pixel
//   CTR_BPB        : pixels per block
//   unpack_state_t : output register state (EMPTY / STREAM)
package ctr_pkg;

  localparam int CTR_DATA_WIDTH = 256;
  localparam int CTR_PIX_WIDTH  = 8;
  localparam int CTR_BPB        = CTR_DATA_WIDTH / CTR_PIX_WIDTH;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/ctr_block_unpacker_if.sv
// ctr_block_unpacker_if: block input strobe and pixel output stream.
//   in_valid / in_data           : one-cycle block strobe, no backpressure
//   m_tvalid / m_tready          : pixel handshake
//   m_tdata / m_tlast            : pixel and end-of-image marker
// Handshake: a pixel transfers on a rising clk edge where m_tvalid and
// m_tready are both high. Once m_tvalid is raised it stays high, and
// m_tdata / m_tlast stay unchanged, until that transfer happens.
// m_tready may change freely and never depends on m_tvalid.
// in_valid has no ready: a block presented is either stored or dropped.
// Modports: slave = the unpacker, master = whoever drives it.
interface ctr_block_unpacker_if
  import ctr_pkg::*;
#(
  parameter int DATA_WIDTH = CTR_DATA_WIDTH,
  parameter int PIX_WIDTH  = CTR_PIX_WIDTH
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  m_tready;
  logic                  m_tvalid;
  logic [PIX_WIDTH-1:0]  m_tdata;
  logic                  m_tlast;

  modport master (
    output in_valid, in_data, m_tready,
    input  m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    input  in_valid, in_data, m_tready,
    output m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/ctr_block_unpacker_fifo.sv
// block_fifo: synchronous FIFO of DATA_WIDTH x DEPTH words.
//   clk, reset : clock, async active-high reset (pointers and level only)
//   push, din  : write din when push (ignored when full unless popping)
//   pop, dout  : dout shows the head word; pop advances (ignored when empty)
//   level      : words held; full / empty derived from it
module block_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem[rd_ptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ctr_block_unpacker.sv
// ctr_block_unpacker: buffers CTR result blocks and serializes them into a
// pixel stream, LSB pixel first, marking the last pixel of each image.
//   clk, reset  : clock, async active-high reset
//   bus         : block strobe in, pixel stream out (see the interface)
//   overflow    : sticky, a block arrived while the FIFO was full
//   fifo_level  : words currently in the block FIFO
//   state_dbg   : output register state
module ctr_block_unpacker
  import ctr_pkg::*;
#(
  parameter int DATA_WIDTH = CTR_DATA_WIDTH,
  parameter int PIX_WIDTH  = CTR_PIX_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_PIXELS = 65536
) (
  input  logic                         clk,
  input  logic                         reset,
  ctr_block_unpacker_if.slave          bus,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output unpack_state_t                state_dbg
);

  localparam int BPB   = DATA_WIDTH / PIX_WIDTH;
  localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int CNT_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_PIXELS - 1);

  unpack_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  img_last, word_end;

  block_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign img_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    // The image end also ends the word: remaining bytes are padding.
    word_end = (idx_q == IDX_LAST) || img_last;
    case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_dout;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (bus.m_tready) begin
          cnt_d = img_last ? '0 : cnt_q + CNT_W'(1);
          if (word_end) begin
            idx_d = '0;
            // Reload in the same cycle so word boundaries have no bubble.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              word_d   = fifo_dout;
            end else begin
              state_d = EMPTY;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    fifo_push  = bus.in_valid && (!fifo_full || fifo_pop);
    overflow_d = overflow_q || (bus.in_valid && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      word_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from registered state, so they hold while stalled.
  assign bus.m_tvalid = (state_q == STREAM);
  assign bus.m_tdata  = (state_q == STREAM) ?
                        word_q[int'(idx_q)*PIX_WIDTH +: PIX_WIDTH] : '0;
  assign bus.m_tlast  = (state_q == STREAM) && img_last;
  assign overflow     = overflow_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ctr_block_unpacker.sv
// Bench for ctr_block_unpacker. Two instances share one stimulus: dut_a uses
// the full image size, dut_b a 40-pixel image to exercise end-of-image padding.
module tb_ctr_block_unpacker;
  import ctr_pkg::*;

  localparam int IMG_A = 65536;
  localparam int IMG_B = 40;
  localparam int BPB   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid;
  logic [255:0] in_data;
  logic         m_tready;

  ctr_block_unpacker_if bus_a ();
  ctr_block_unpacker_if bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_a.m_tready = m_tready;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.m_tready = m_tready;

  logic          ovf_a, ovf_b;
  logic [2:0]    lvl_a, lvl_b;
  unpack_state_t st_a, st_b;

  ctr_block_unpacker #(.DATA_WIDTH(256), .PIX_WIDTH(8), .FIFO_DEPTH(4), .IMG_PIXELS(IMG_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .overflow(ovf_a), .fifo_level(lvl_a), .state_dbg(st_a)
  );

  ctr_block_unpacker #(.DATA_WIDTH(256), .PIX_WIDTH(8), .FIFO_DEPTH(4), .IMG_PIXELS(IMG_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .overflow(ovf_b), .fifo_level(lvl_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  int cnt_a, cnt_b;
  int n_cmp = 0;
  int n_err = 0;

  int   hs_n[2], last_n[2], first_hs[2], last_hs[2];
  logic stalled[2], st_last[2];
  logic [7:0] st_data[2], last_data[2];
  int   cyc = 0;
  int   max_lvl_a = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pixels per instance, with an independent image counter each.
  task automatic sb_push_block(input logic [255:0] blk);
    logic [7:0] b;
    logic       l;
    for (int p = 0; p < BPB; p++) begin
      b = blk[p*8 +: 8];
      l = (cnt_a == IMG_A - 1);
      exp_q_a.push_back({l, b});
      if (l) begin cnt_a = 0; break; end
      cnt_a++;
    end
    for (int p = 0; p < BPB; p++) begin
      b = blk[p*8 +: 8];
      l = (cnt_b == IMG_B - 1);
      exp_q_b.push_back({l, b});
      if (l) begin cnt_b = 0; break; end
      cnt_b++;
    end
  endtask

  task automatic sb_clear();
    exp_q_a.delete();
    exp_q_b.delete();
    cnt_a = 0;
    cnt_b = 0;
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
  endtask

  task automatic clr_stats();
    for (int d = 0; d < 2; d++) begin
      hs_n[d] = 0; last_n[d] = 0; first_hs[d] = -1; last_hs[d] = -1;
    end
    max_lvl_a = 0;
  endtask

  task automatic mon_step(input int d, input logic v, input logic r, input logic l, input logic [7:0] data);
    logic [8:0] e;
    string sfx;
    sfx = (d == 0) ? "_a" : "_b";
    if (v) begin
      if (stalled[d]) begin
        check_eq({"stable_data", sfx}, 64'(data), 64'(st_data[d]));
        check_eq({"stable_last", sfx}, 64'(l), 64'(st_last[d]));
      end
      if (r) begin
        hs_n[d]++;
        if (first_hs[d] < 0) first_hs[d] = cyc;
        last_hs[d] = cyc;
        if (l) begin last_n[d]++; last_data[d] = data; end
        if (d == 0) begin
          check_eq({"sb_nonempty", sfx}, 64'(exp_q_a.size() != 0), 64'(1));
          if (exp_q_a.size() != 0) begin e = exp_q_a.pop_front(); check_eq({"pixel", sfx}, 64'({l, data}), 64'(e)); end
        end else begin
          check_eq({"sb_nonempty", sfx}, 64'(exp_q_b.size() != 0), 64'(1));
          if (exp_q_b.size() != 0) begin e = exp_q_b.pop_front(); check_eq({"pixel", sfx}, 64'({l, data}), 64'(e)); end
        end
        stalled[d] = 1'b0;
      end else begin
        stalled[d] = 1'b1;
        st_data[d] = data;
        st_last[d] = l;
      end
    end else begin
      stalled[d] = 1'b0;
    end
  endtask

  // Monitor samples on the falling edge; a handshake seen here completes at
  // the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (int'(lvl_a) > max_lvl_a) max_lvl_a = int'(lvl_a);
      mon_step(0, bus_a.m_tvalid, m_tready, bus_a.m_tlast, bus_a.m_tdata);
      mon_step(1, bus_b.m_tvalid, m_tready, bus_b.m_tlast, bus_b.m_tdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_block(input logic [255:0] blk, input bit kept);
    in_valid = 1'b1;
    in_data  = blk;
    if (kept) sb_push_block(blk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [255:0] rand_blk();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // pat 0: ready always high; pat 1: ready 1,0,0 repeating.
  task automatic wait_drain(input int pat);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      m_tready = (pat == 0) ? 1'b1 : (c % 3 == 0);
      @(posedge clk);
      #1;
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && !bus_a.m_tvalid && !bus_b.m_tvalid) done = 1'b1;
    end
    check_eq("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] b1, b2, b3, seq;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; m_tready = 1'b0;
    sb_clear();
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(bus_a.m_tvalid), 64'(0));
    check_eq("rst_tdata", 64'(bus_a.m_tdata), 64'(0));
    check_eq("rst_tlast", 64'(bus_a.m_tlast), 64'(0));
    check_eq("rst_overflow", 64'(ovf_a), 64'(0));
    check_eq("rst_level", 64'(lvl_a), 64'(0));
    check_eq("rst_state", 64'(st_a), 64'(EMPTY));
    reset = 1'b0;
    @(posedge clk); #1;

    // Image end with padding (dut_b, 40-pixel image).
    clr_stats();
    m_tready = 1'b1;
    b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
    drive_block(b1, 1); drive_block(b2, 1); drive_block(b3, 1);
    wait_drain(0);
    check_eq("img_tlast_count_b", 64'(last_n[1]), 64'(1));
    check_eq("img_tlast_pixel_b", 64'(last_data[1]), 64'(b2[63:56]));
    check_eq("img_pixels_b", 64'(hs_n[1]), 64'(72));
    check_eq("img_pixels_a", 64'(hs_n[0]), 64'(96));
    check_eq("img_tlast_count_a", 64'(last_n[0]), 64'(0));

    // Single block, latency.
    clr_stats();
    for (int i = 0; i < 32; i++) seq[i*8 +: 8] = 8'(i);
    in_valid = 1'b1; in_data = seq; sb_push_block(seq);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("lat_level", 64'(lvl_a), 64'(1));
    check_eq("lat_tvalid_early", 64'(bus_a.m_tvalid), 64'(0));
    @(posedge clk); #1;
    check_eq("lat_tvalid", 64'(bus_a.m_tvalid), 64'(1));
    check_eq("lat_first_pixel", 64'(bus_a.m_tdata), 64'(0));
    wait_drain(0);
    check_eq("single_pixels", 64'(hs_n[0]), 64'(32));
    check_eq("single_tlast", 64'(last_n[0]), 64'(0));

    // Back-to-back blocks.
    clr_stats();
    drive_block(rand_blk(), 1); drive_block(rand_blk(), 1); drive_block(rand_blk(), 1);
    wait_drain(0);
    check_eq("b2b_pixels", 64'(hs_n[0]), 64'(96));
    check_eq("b2b_no_bubble", 64'(last_hs[0] - first_hs[0]), 64'(95));
    check_eq("b2b_level_peak", 64'(max_lvl_a), 64'(2));

    // Backpressure.
    clr_stats();
    drive_block(rand_blk(), 1); drive_block(rand_blk(), 1);
    wait_drain(1);
    check_eq("bp_pixels", 64'(hs_n[0]), 64'(64));

    // Overflow.
    clr_stats();
    m_tready = 1'b0;
    for (int k = 0; k < 6; k++) drive_block(rand_blk(), k < 5);
    check_eq("ovf_level", 64'(lvl_a), 64'(4));
    check_eq("ovf_flag_a", 64'(ovf_a), 64'(1));
    check_eq("ovf_flag_b", 64'(ovf_b), 64'(1));
    check_eq("ovf_tvalid", 64'(bus_a.m_tvalid), 64'(1));
    wait_drain(0);
    check_eq("ovf_pixels", 64'(hs_n[0]), 64'(160));
    check_eq("ovf_sticky", 64'(ovf_a), 64'(1));

    // Reset mid-stream.
    m_tready = 1'b0;
    drive_block(rand_blk(), 1); drive_block(rand_blk(), 1); drive_block(rand_blk(), 1);
    repeat (3) @(posedge clk);
    #1;
    clr_stats();
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    m_tready = 1'b0;
    check_eq("mid_pixels", 64'(hs_n[0]), 64'(10));
    check_eq("mid_level", 64'(lvl_a), 64'(2));
    #2;
    reset = 1'b1;
    sb_clear();
    #1;
    check_eq("arst_tvalid", 64'(bus_a.m_tvalid), 64'(0));
    check_eq("arst_tdata", 64'(bus_a.m_tdata), 64'(0));
    check_eq("arst_tlast", 64'(bus_a.m_tlast), 64'(0));
    check_eq("arst_level_a", 64'(lvl_a), 64'(0));
    check_eq("arst_level_b", 64'(lvl_b), 64'(0));
    check_eq("arst_overflow", 64'(ovf_a), 64'(0));
    check_eq("arst_state", 64'(st_a), 64'(EMPTY));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    clr_stats();
    drive_block(seq, 1);
    wait_drain(0);
    check_eq("post_rst_pixels", 64'(hs_n[0]), 64'(32));
    check_eq("post_rst_tlast_b", 64'(last_n[1]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
